cordic_xy_rotator: RTL and testbench

//   Iterative CORDIC vector rotator, downstream of the angle-convergence stage.

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_xy_step.sv | 20 ++
 rtl/cordic_xy_rotator.sv | 133 +++++++++++++
 tb/tb_cordic_xy_rotator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and helpers for the CORDIC vector rotator.
// The angle stage's arctan table lives here so both stages use one copy.
package cordic_pkg;
  localparam int XY_W_DEF   = 12;
  localparam int ITER_DEF   = 8;
  localparam int K_INIT_DEF = 622;

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_e;

  // Step counter needs at least one bit even when only one micro-rotation is run.
  function automatic int step_w(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

  localparam int STEP_W = step_w(ITER_DEF);

  // arctan(2^-i), 256 units = 180 degrees
  localparam logic [7:0] ATAN_TAB [8] = '{8'd64, 8'd38, 8'd20, 8'd10,
                                          8'd5,  8'd3,  8'd1,  8'd1};
endpackage

// File: rtl/cordic_xy_step.sv
// Single combinational CORDIC micro-rotation: rotates (X,Y) by +/-arctan(2^-i).
module cordic_xy_step #(
  parameter int XY_W = 12,
  parameter int SH_W = 3
) (
  input  logic signed [XY_W-1:0] x_i,
  input  logic signed [XY_W-1:0] y_i,
  input  logic        [SH_W-1:0] shift_i,
  input  logic                   dir_i,
  output logic signed [XY_W-1:0] x_o,
  output logic signed [XY_W-1:0] y_o
);
  logic signed [XY_W-1:0] xs, ys;

  assign xs  = x_i >>> shift_i;
  assign ys  = y_i >>> shift_i;
  // dir 0 rotates counter-clockwise, dir 1 clockwise; sums wrap to XY_W
  assign x_o = dir_i ? (x_i + ys) : (x_i - ys);
  assign y_o = dir_i ? (y_i - xs) : (y_i + xs);
endmodule

// File: rtl/cordic_xy_rotator.sv
// Iterative CORDIC rotator: one direction bit per step, returns cos/sin of (K,0) rotated.
// Optional QUADRANT_EN macro adds a quadrant input that remaps the final result.
module cordic_xy_rotator
  import cordic_pkg::*;
#(
  parameter int XY_W   = XY_W_DEF,
  parameter int ITER   = ITER_DEF,
  parameter int K_INIT = K_INIT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  output logic            ready_o,
  input  logic            dir_i,
  input  logic            dir_valid_i,
  output logic            dir_ready_o,
`ifdef QUADRANT_EN
  input  logic [1:0]      quadrant_i,
`endif
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XY_W-1:0] cos_o,
  output logic [XY_W-1:0] sin_o
);
  localparam int            SW   = step_w(ITER);
  localparam logic [SW-1:0] LAST = SW'(ITER - 1);

  state_e                 state_q, state_d;
  logic signed [XY_W-1:0] x_q, x_d, y_q, y_d;
  logic signed [XY_W-1:0] cos_q, cos_d, sin_q, sin_d;
  logic signed [XY_W-1:0] x_nx, y_nx, c_fin, s_fin;
  logic        [SW-1:0]   step_q, step_d;

  cordic_xy_step #(.XY_W(XY_W), .SH_W(SW)) u_step (
    .x_i     (x_q),
    .y_i     (y_q),
    .shift_i (step_q),
    .dir_i   (dir_i),
    .x_o     (x_nx),
    .y_o     (y_nx)
  );

`ifdef QUADRANT_EN
  logic [1:0] quad_q, quad_d;

  // Map the first-quadrant result onto the latched quadrant at the final write
  always_comb begin
    c_fin = x_nx;
    s_fin = y_nx;
    case (quad_q)
      2'd1: begin c_fin = -y_nx; s_fin =  x_nx; end
      2'd2: begin c_fin = -x_nx; s_fin = -y_nx; end
      2'd3: begin c_fin =  y_nx; s_fin = -x_nx; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) quad_q <= 2'd0;
    else        quad_q <= quad_d;
  end
`else
  assign c_fin = x_nx;
  assign s_fin = y_nx;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    step_d  = step_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
`ifdef QUADRANT_EN
    quad_d  = quad_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d     = XY_W'(K_INIT);
          y_d     = '0;
          step_d  = '0;
`ifdef QUADRANT_EN
          quad_d  = quadrant_i;
`endif
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        // No direction bit this cycle means a stall: X, Y and step hold
        if (dir_valid_i) begin
          x_d = x_nx;
          y_d = y_nx;
          if (step_q == LAST) begin
            cos_d   = c_fin;
            sin_d   = s_fin;
            state_d = DONE;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      step_q  <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      step_q  <= step_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign dir_ready_o = (state_q == ROTATE);
  assign out_valid_o = (state_q == DONE);
  assign cos_o       = cos_q;
  assign sin_o       = sin_q;
endmodule

// File: tb/tb_cordic_xy_rotator.sv
// Self-checking bench: ITER=1/2/8 instances against an integer CORDIC reference model.
module tb_cordic_xy_rotator;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] start, dir, dv, ordy, rdy, drdy, ov;
  logic [2:0][11:0] cosv, sinv;
  logic [2:0][1:0]  quad;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cordic_xy_rotator #(.ITER(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .ready_o(rdy[0]), .dir_i(dir[0]),
    .dir_valid_i(dv[0]), .dir_ready_o(drdy[0]),
`ifdef QUADRANT_EN
    .quadrant_i(quad[0]),
`endif
    .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .cos_o(cosv[0]), .sin_o(sinv[0]));

  cordic_xy_rotator #(.ITER(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .ready_o(rdy[1]), .dir_i(dir[1]),
    .dir_valid_i(dv[1]), .dir_ready_o(drdy[1]),
`ifdef QUADRANT_EN
    .quadrant_i(quad[1]),
`endif
    .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .cos_o(cosv[1]), .sin_o(sinv[1]));

  cordic_xy_rotator u8 (
    .clk(clk), .rst_n(rst_n), .start_i(start[2]), .ready_o(rdy[2]), .dir_i(dir[2]),
    .dir_valid_i(dv[2]), .dir_ready_o(drdy[2]),
`ifdef QUADRANT_EN
    .quadrant_i(quad[2]),
`endif
    .out_valid_o(ov[2]), .out_ready_i(ordy[2]), .cos_o(cosv[2]), .sin_o(sinv[2]));

  // Reference: plain integer CORDIC from (622,0), wrap to 12 bits, then quadrant map
  function automatic logic [23:0] model(input int n, input logic [7:0] d, input logic [1:0] q);
    int x, y, xs, ys, nx, ny, c, s;
    logic signed [11:0] t;
    x = 622; y = 0;
    for (int i = 0; i < n; i++) begin
      xs = x >>> i; ys = y >>> i;
      nx = d[i] ? x + ys : x - ys;
      ny = d[i] ? y - xs : y + xs;
      t = 12'(nx); x = int'(t);
      t = 12'(ny); y = int'(t);
    end
    case (q)
      2'd1:    begin c = -y; s =  x; end
      2'd2:    begin c = -x; s = -y; end
      2'd3:    begin c =  y; s = -x; end
      default: begin c =  x; s =  y; end
    endcase
    return {12'(c), 12'(s)};
  endfunction

  // Starts an op, feeds n direction bits (optionally every other cycle) and
  // returns the number of edges after the START edge until OUT_VALID is seen.
  task automatic run_op(input int idx, input int n, input logic [7:0] d,
                        input logic [1:0] q, input bit toggle, output int lat);
    int k;
    k = 0; lat = 0;
    @(negedge clk);
    start[idx] = 1'b1; quad[idx] = q; dv[idx] = 1'b0;
    @(negedge clk);
    start[idx] = 1'b0;
    while (!ov[idx] && lat < 64) begin
      dv[idx]  = (k < n) && (!toggle || (lat % 2 == 0));
      dir[idx] = d[k % 8];
      @(negedge clk);
      lat++;
      if (dv[idx]) k++;
    end
    dv[idx] = 1'b0;
  endtask

  // Completes the output handshake with START asserted alongside OUT_READY.
  task automatic finish_op(input int idx);
    ordy[idx] = 1'b1; start[idx] = 1'b1;
    @(negedge clk);
    ordy[idx] = 1'b0; start[idx] = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ov[i] !== 1'b0) begin errors++; $display("FAIL reset_ov[%0d]: got %b want 0", i, ov[i]); end
      checks++; if (rdy[i] !== 1'b1 || drdy[i] !== 1'b0) begin errors++; $display("FAIL reset_rdy[%0d]: got %b/%b want 1/0", i, rdy[i], drdy[i]); end
      checks++; if (cosv[i] !== 12'd0 || sinv[i] !== 12'd0) begin errors++; $display("FAIL reset_cs[%0d]: got %0d/%0d want 0/0", i, cosv[i], sinv[i]); end
    end
  endtask

  task automatic test_iter1;
    int lat;
    run_op(0, 1, 8'h00, 2'd0, 1'b0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL iter1_lat: got %0d want 1", lat); end
    checks++; if (cosv[0] !== 12'd622 || sinv[0] !== 12'd622) begin errors++; $display("FAIL iter1_cs: got %0d/%0d want 622/622", $signed(cosv[0]), $signed(sinv[0])); end
    finish_op(0);
    checks++; if (ov[0] !== 1'b0 || rdy[0] !== 1'b1) begin errors++; $display("FAIL iter1_hs: got ov=%b rdy=%b want 0/1", ov[0], rdy[0]); end
`ifdef QUADRANT_EN
    run_op(0, 1, 8'h00, 2'd2, 1'b0, lat);
    checks++; if ($signed(cosv[0]) !== -12'sd622 || $signed(sinv[0]) !== -12'sd622) begin errors++; $display("FAIL iter1_quad2: got %0d/%0d want -622/-622", $signed(cosv[0]), $signed(sinv[0])); end
    finish_op(0);
`endif
  endtask

  task automatic test_iter2;
    int lat;
    run_op(1, 2, 8'b0000_0010, 2'd0, 1'b0, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL iter2_lat: got %0d want 2", lat); end
    checks++; if (cosv[1] !== 12'd933 || sinv[1] !== 12'd311) begin errors++; $display("FAIL iter2_cs: got %0d/%0d want 933/311", $signed(cosv[1]), $signed(sinv[1])); end
    finish_op(1);
  endtask

  task automatic test_iter8(input bit toggle);
    int lat, want_lat;
    logic [23:0] e;
    e = model(8, 8'h2E, 2'd0);
    want_lat = toggle ? 15 : 8;
    run_op(2, 8, 8'h2E, 2'd0, toggle, lat);
    checks++; if (lat !== want_lat) begin errors++; $display("FAIL iter8_lat(t=%0d): got %0d want %0d", toggle, lat, want_lat); end
    checks++; if ({cosv[2], sinv[2]} !== e) begin errors++; $display("FAIL iter8_cs(t=%0d): got %0d/%0d want %0d/%0d", toggle, $signed(cosv[2]), $signed(sinv[2]), $signed(e[23:12]), $signed(e[11:0])); end
    checks++; if ($signed(cosv[2]) < 1018 || $signed(cosv[2]) > 1030 || $signed(sinv[2]) < 1 || $signed(sinv[2]) > 13) begin errors++; $display("FAIL iter8_range(t=%0d): got %0d/%0d want 1024+-6/7+-6", toggle, $signed(cosv[2]), $signed(sinv[2])); end
    finish_op(2);
    checks++; if (rdy[2] !== 1'b1 || drdy[2] !== 1'b0) begin errors++; $display("FAIL iter8_idle(t=%0d): got rdy=%b drdy=%b want 1/0", toggle, rdy[2], drdy[2]); end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [23:0] e;
    e = model(8, 8'h5A, 2'd0);
    run_op(2, 8, 8'h5A, 2'd0, 1'b0, lat);
    for (int j = 0; j < 5; j++) begin
      start[2] = j[0];
      @(negedge clk);
      checks++; if (ov[2] !== 1'b1 || {cosv[2], sinv[2]} !== e) begin errors++; $display("FAIL bp_hold[%0d]: got ov=%b %0d/%0d want 1 %0d/%0d", j, ov[2], $signed(cosv[2]), $signed(sinv[2]), $signed(e[23:12]), $signed(e[11:0])); end
    end
    start[2] = 1'b0;
    finish_op(2);
    checks++; if (ov[2] !== 1'b0 || rdy[2] !== 1'b1 || drdy[2] !== 1'b0) begin errors++; $display("FAIL bp_release: got ov=%b rdy=%b drdy=%b want 0/1/0", ov[2], rdy[2], drdy[2]); end
    checks++; if ({cosv[2], sinv[2]} !== e) begin errors++; $display("FAIL bp_keep: got %0d/%0d want %0d/%0d", $signed(cosv[2]), $signed(sinv[2]), $signed(e[23:12]), $signed(e[11:0])); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0; dv[2] = 1'b1; dir[2] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ov[2] !== 1'b0 || rdy[2] !== 1'b1 || drdy[2] !== 1'b0) begin errors++; $display("FAIL rstmid_ctl: got ov=%b rdy=%b drdy=%b want 0/1/0", ov[2], rdy[2], drdy[2]); end
    checks++; if (cosv[2] !== 12'd0 || sinv[2] !== 12'd0) begin errors++; $display("FAIL rstmid_cs: got %0d/%0d want 0/0", cosv[2], sinv[2]); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (ov[2] !== 1'b0 || rdy[2] !== 1'b1) begin errors++; $display("FAIL rstmid_after: got ov=%b rdy=%b want 0/1", ov[2], rdy[2]); end
    dv[2] = 1'b0;
  endtask

  task automatic test_back_to_back;
    int lat, want_lat, dly;
    logic [7:0] d;
    logic [1:0] q;
    bit tg;
    logic [23:0] e;
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      tg = 1'($urandom_range(0, 1));
`ifdef QUADRANT_EN
      q = 2'($urandom_range(0, 3));
`else
      q = 2'd0;
`endif
      e = model(8, d, q);
      want_lat = tg ? 15 : 8;
      run_op(2, 8, d, q, tg, lat);
      checks++; if (lat !== want_lat) begin errors++; $display("FAIL b2b_lat[%0d]: got %0d want %0d", n, lat, want_lat); end
      checks++; if ({cosv[2], sinv[2]} !== e) begin errors++; $display("FAIL b2b_cs[%0d] d=%h q=%0d: got %0d/%0d want %0d/%0d", n, d, q, $signed(cosv[2]), $signed(sinv[2]), $signed(e[23:12]), $signed(e[11:0])); end
      dly = $urandom_range(0, 3);
      for (int j = 0; j < dly; j++) @(negedge clk);
      checks++; if (ov[2] !== 1'b1) begin errors++; $display("FAIL b2b_hold[%0d]: got %b want 1", n, ov[2]); end
      finish_op(2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0; dir = '0; dv = '0; ordy = '0; quad = '0;
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_iter1;
    test_iter2;
    test_iter8(1'b0);
    test_iter8(1'b1);
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
